// File: rtl/data_counter_sequencer.sv
// ---------------------------------------------------------------------------
// data_counter_sequencer
//
// Command-driven controller for a 3-digit dekatron data counter (0..255).
// It turns INC-by-N, DEC-by-N and LOAD commands into timed Step, Reverse and
// Set pulses. It keeps a binary shadow of the counter value and checks the
// counter's BCD readback after every pulse.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rstN      synchronous active-low reset (shared with the counter)
//   i_cmdValid  command present
//   o_cmdReady  high only while idle; accept = i_cmdValid & o_cmdReady
//   i_cmdOp     00 NOP, 01 INC, 10 DEC, 11 LOAD
//   i_cmdArg    INC/DEC: step count N; LOAD: binary value
//   o_done      one-cycle pulse when a command completes or aborts
//   o_busy      high from the cycle after accept through the done cycle
//   o_error     readback mismatch, sticky until the next accepted command
//   o_value     binary shadow of the counter value
//   o_step      counter Step
//   o_reverse   counter Reverse (1 = count down)
//   o_set       counter Set
//   o_in        counter In, BCD {hundreds[1:0], tens, ones}
//   i_out       counter readback, same BCD format
// ---------------------------------------------------------------------------
module data_counter_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 8
) (
    input  logic       i_clk,
    input  logic       i_rstN,
    input  logic       i_cmdValid,
    output logic       o_cmdReady,
    input  logic [1:0] i_cmdOp,
    input  logic [7:0] i_cmdArg,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_error,
    output logic [7:0] o_value,
    output logic       o_step,
    output logic       o_reverse,
    output logic       o_set,
    output logic [9:0] o_in,
    input  logic [9:0] i_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_CHECK,
        S_FIN
    } state_t;

    localparam logic [1:0]  OP_NOP     = 2'b00;
    localparam logic [1:0]  OP_INC     = 2'b01;
    localparam logic [1:0]  OP_DEC     = 2'b10;
    localparam logic [1:0]  OP_LOAD    = 2'b11;
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_op;
    logic [7:0]  r_arg;
    logic [7:0]  r_stepsLeft;
    logic [15:0] r_timer;
    logic [7:0]  r_value;
    logic        r_error;

    logic        w_accept;
    logic        w_active;
    logic [7:0]  w_nextValue;
    logic        w_mismatch;

    // Binary to BCD; the hundreds digit never exceeds 2 so two bits suffice.
    function automatic logic [9:0] toBcd(input logic [7:0] v);
        return {2'(v / 8'd100), 4'((v % 8'd100) / 8'd10), 4'(v % 8'd10)};
    endfunction

    assign w_accept = i_cmdValid && (r_state == S_IDLE);

    // Set, Reverse and In stay stable from SETUP until the pulse train ends,
    // so the counter never sees them change around a Step edge.
    assign w_active = (r_state == S_SETUP) || (r_state == S_PULSE) ||
                      (r_state == S_GAP)   || (r_state == S_CHECK);

    // The value the counter should hold after the pulse just issued; the
    // readback is compared against this, not against the old shadow.
    always_comb begin
        w_nextValue = r_value;
        case (r_op)
            OP_INC:  w_nextValue = r_value + 8'd1;
            OP_DEC:  w_nextValue = r_value - 8'd1;
            OP_LOAD: w_nextValue = r_arg;
            default: w_nextValue = r_value;
        endcase
    end

    assign w_mismatch = (i_out != toBcd(w_nextValue));

    // State register; reset aborts a running command without a done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. After a good readback with steps left the FSM goes
    // straight back to PULSE, since Reverse is already set up.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((i_cmdOp == OP_NOP) ||
                        ((i_cmdOp != OP_LOAD) && (i_cmdArg == 8'd0))) begin
                        w_nextState = S_FIN;
                    end else begin
                        w_nextState = S_SETUP;
                    end
                end
            end
            S_SETUP: w_nextState = S_PULSE;
            S_PULSE: if (r_timer == PULSE_LAST) w_nextState = S_GAP;
            S_GAP:   if (r_timer == GAP_LAST) w_nextState = S_CHECK;
            S_CHECK: begin
                if (w_mismatch || (r_stepsLeft <= 8'd1)) begin
                    w_nextState = S_FIN;
                end else begin
                    w_nextState = S_PULSE;
                end
            end
            S_FIN:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state and the latched command.
    always_comb begin
        o_cmdReady = (r_state == S_IDLE);
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_FIN);
        o_step     = (r_state == S_PULSE);
        o_reverse  = w_active && (r_op == OP_DEC);
        o_set      = w_active && (r_op == OP_LOAD);
        o_in       = 10'd0;
        if (w_active && (r_op == OP_LOAD)) begin
            o_in = toBcd(r_arg);
        end
        o_value    = r_value;
        o_error    = r_error;
    end

    // Datapath: command latch, phase timer, step countdown, shadow value
    // and the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_op        <= OP_NOP;
            r_arg       <= 8'd0;
            r_stepsLeft <= 8'd0;
            r_timer     <= 16'd0;
            r_value     <= 8'd0;
            r_error     <= 1'b0;
        end else begin
            if (w_nextState != r_state) begin
                r_timer <= 16'd0;
            end else if ((r_state == S_PULSE) || (r_state == S_GAP)) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_accept) begin
                r_op        <= i_cmdOp;
                r_arg       <= i_cmdArg;
                r_error     <= 1'b0;
                r_stepsLeft <= (i_cmdOp == OP_LOAD) ? 8'd1 : i_cmdArg;
            end

            if (r_state == S_CHECK) begin
                r_value     <= w_nextValue;
                r_stepsLeft <= r_stepsLeft - 8'd1;
                if (w_mismatch) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_data_counter_sequencer
//
// Bench for data_counter_sequencer. A behavioural dekatron counter reacts to
// the Step/Reverse/Set/In pulses and drives the BCD readback, with an option
// to corrupt the readback after a chosen number of pulses. Expected values
// come from command-level arithmetic: final value, pulse count and the
// cycle in which done should appear.
// ---------------------------------------------------------------------------
module tb_data_counter_sequencer;

    localparam int P = 4;
    localparam int G = 8;
    localparam int BUDGET = 4000;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       cmdValid = 1'b0;
    logic [1:0] cmdOp = 2'b00;
    logic [7:0] cmdArg = 8'd0;
    logic       cmdReady, dutDone, dutBusy, dutError;
    logic [7:0] dutValue;
    logic       dutStep, dutReverse, dutSet;
    logic [9:0] dutIn;
    logic [9:0] counterOut;

    int checks = 0;
    int fails  = 0;

    // Counter model state.
    int ctr = 0;
    int modelPulses = 0;
    bit faultEn = 1'b0;
    int faultBase = 0;
    logic prevStep = 1'b0;

    // Per-cycle history of the most recent command (index = cycle number).
    bit stepHist [0:BUDGET];
    bit revHist  [0:BUDGET];
    int valHist  [0:BUDGET];
    int histLen;
    int setPulses;
    logic [9:0] setIn;

    // Shadow expected by the bench, tracked from command semantics.
    int expValue = 0;

    data_counter_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .i_clk(clk), .i_rstN(rstN), .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
        .i_cmdOp(cmdOp), .i_cmdArg(cmdArg), .o_done(dutDone), .o_busy(dutBusy),
        .o_error(dutError), .o_value(dutValue), .o_step(dutStep),
        .o_reverse(dutReverse), .o_set(dutSet), .o_in(dutIn), .i_out(counterOut)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] tbBcd(input int v);
        logic [9:0] r;
        r[9:8] = 2'(v / 100);
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int fromBcd(input logic [9:0] b);
        return int'(b[9:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Dekatron counter: acts on each Step rise, loads on Set, resets with Rst_n.
    always @(negedge clk) begin
        if (!rstN) begin
            ctr = 0;
            prevStep = 1'b0;
        end else begin
            if (dutStep && !prevStep) begin
                modelPulses = modelPulses + 1;
                if (dutSet) ctr = fromBcd(dutIn);
                else if (dutReverse) ctr = (ctr + 255) % 256;
                else ctr = (ctr + 1) % 256;
            end
            prevStep = dutStep;
        end
    end

    assign counterOut = (faultEn && (modelPulses - faultBase >= 2)) ?
                        (tbBcd(ctr) ^ 10'h001) : tbBcd(ctr);

    function automatic int expDone(input logic [1:0] op, input int arg);
        if (op == 2'b00) return 1;
        if (op == 2'b11) return 2 + P + G + 1;
        if (arg == 0) return 1;
        return 2 + arg * (P + G + 1);
    endfunction

    function automatic int expPulses(input logic [1:0] op, input int arg);
        if (op == 2'b00) return 0;
        if (op == 2'b11) return 1;
        return arg;
    endfunction

    function automatic int nextValue(input int v, input logic [1:0] op, input int arg, input int n);
        if (op == 2'b01) return (v + n) % 256;
        if (op == 2'b10) return (v - n + 256 * 2) % 256;
        if (op == 2'b11) return arg;
        return v;
    endfunction

    function automatic int countRises();
        int n = 0;
        for (int c = 1; c <= histLen; c++) if (stepHist[c] && !stepHist[c-1]) n++;
        return n;
    endfunction

    function automatic int firstRise();
        for (int c = 1; c <= histLen; c++) if (stepHist[c] && !stepHist[c-1]) return c;
        return -1;
    endfunction

    // Counts Step pulses that are not exactly P cycles high followed by G low.
    function automatic int badShapes();
        int bad = 0;
        for (int c = 1; c <= histLen; c++) begin
            if (stepHist[c] && !stepHist[c-1]) begin
                for (int k = 0; k < P + G; k++) begin
                    if ((c + k > histLen) || (stepHist[c+k] != (k < P))) begin
                        bad++;
                        break;
                    end
                end
            end
        end
        return bad;
    endfunction

    // Presents one command, then samples every cycle until done or the budget.
    task automatic runCmd(input logic [1:0] op, input logic [7:0] arg,
                          output int doneCycle, output int readyViol);
        @(negedge clk);
        cmdValid = 1'b1; cmdOp = op; cmdArg = arg;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0; cmdOp = 2'b00; cmdArg = 8'd0;
        doneCycle = -1; readyViol = 0; setPulses = 0; setIn = 10'd0;
        stepHist[0] = 1'b0;
        histLen = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            stepHist[c] = dutStep;
            revHist[c]  = dutReverse;
            valHist[c]  = int'(dutValue);
            if (dutSet && dutStep) begin setPulses++; setIn = dutIn; end
            if (cmdReady) readyViol++;
            histLen = c;
            if (dutDone) begin doneCycle = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checks++; if (dutValue !== 8'd0) begin fails++; $display("[TB] FAIL reset_value: got %0d expected 0", dutValue); end
        checks++; if (cmdReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", cmdReady); end
        checks++; if (dutStep !== 1'b0) begin fails++; $display("[TB] FAIL reset_step: got %b expected 0", dutStep); end
        checks++; if (dutError !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b expected 0", dutError); end
        checks++; if ({dutDone, dutBusy, dutSet, dutReverse} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {dutDone, dutBusy, dutSet, dutReverse}); end
        checks++; if (dutIn !== 10'd0) begin fails++; $display("[TB] FAIL reset_in: got %b expected 0", dutIn); end
        expValue = 0;
    endtask

    task automatic test_inc();
        int d, rv, revOnes;
        runCmd(2'b01, 8'd3, d, rv);
        expValue = nextValue(expValue, 2'b01, 3, 3);
        revOnes = 0;
        for (int c = 1; c <= histLen; c++) if (revHist[c]) revOnes++;
        checks++; if (d !== 41) begin fails++; $display("[TB] FAIL inc3_done: got %0d expected 41", d); end
        checks++; if (countRises() !== 3) begin fails++; $display("[TB] FAIL inc3_pulses: got %0d expected 3", countRises()); end
        checks++; if (firstRise() !== 2) begin fails++; $display("[TB] FAIL inc3_first_rise: got %0d expected 2", firstRise()); end
        checks++; if (badShapes() !== 0) begin fails++; $display("[TB] FAIL inc3_shape: got %0d bad pulses expected 0", badShapes()); end
        checks++; if (revOnes !== 0) begin fails++; $display("[TB] FAIL inc3_reverse: got %0d high cycles expected 0", revOnes); end
        checks++; if (int'(dutValue) !== expValue) begin fails++; $display("[TB] FAIL inc3_value: got %0d expected %0d", dutValue, expValue); end
        checks++; if (dutError !== 1'b0) begin fails++; $display("[TB] FAIL inc3_error: got %b expected 0", dutError); end
        checks++; if (rv !== 0) begin fails++; $display("[TB] FAIL inc3_ready_busy: got %0d ready cycles expected 0", rv); end
    endtask

    task automatic test_load_wrap();
        int d, rv;
        runCmd(2'b11, 8'd250, d, rv);
        expValue = 250;
        checks++; if (d !== 15) begin fails++; $display("[TB] FAIL load_done: got %0d expected 15", d); end
        checks++; if (setPulses !== P) begin fails++; $display("[TB] FAIL load_set_step: got %0d expected %0d", setPulses, P); end
        checks++; if (setIn !== 10'b10_0101_0000) begin fails++; $display("[TB] FAIL load_in: got %b expected 1001010000", setIn); end
        checks++; if (int'(dutValue) !== expValue) begin fails++; $display("[TB] FAIL load_value: got %0d expected %0d", dutValue, expValue); end
        runCmd(2'b01, 8'd10, d, rv);
        expValue = nextValue(expValue, 2'b01, 10, 10);
        checks++; if (d !== 132) begin fails++; $display("[TB] FAIL wrap_done: got %0d expected 132", d); end
        checks++; if (int'(dutValue) !== 4) begin fails++; $display("[TB] FAIL wrap_value: got %0d expected 4", dutValue); end
        checks++; if (counterOut !== 10'b00_0000_0100) begin fails++; $display("[TB] FAIL wrap_out: got %b expected 0000000100", counterOut); end
        checks++; if (dutError !== 1'b0) begin fails++; $display("[TB] FAIL wrap_error: got %b expected 0", dutError); end
    endtask

    task automatic test_dec();
        int d, rv, revLow;
        runCmd(2'b11, 8'd0, d, rv);
        expValue = 0;
        runCmd(2'b10, 8'd2, d, rv);
        expValue = nextValue(expValue, 2'b10, 2, 2);
        revLow = 0;
        for (int c = 1; c <= d - 2; c++) if (!revHist[c]) revLow++;
        checks++; if (d !== 28) begin fails++; $display("[TB] FAIL dec2_done: got %0d expected 28", d); end
        checks++; if (revLow !== 0) begin fails++; $display("[TB] FAIL dec2_reverse_held: got %0d low cycles expected 0", revLow); end
        checks++; if (d > 0 && revHist[d] !== 1'b0) begin fails++; $display("[TB] FAIL dec2_reverse_fin: got %b expected 0", revHist[d]); end
        checks++; if (valHist[15] !== 255) begin fails++; $display("[TB] FAIL dec2_mid_value: got %0d expected 255", valHist[15]); end
        checks++; if (int'(dutValue) !== expValue) begin fails++; $display("[TB] FAIL dec2_value: got %0d expected %0d", dutValue, expValue); end
    endtask

    task automatic test_error();
        int d, rv;
        faultBase = modelPulses;
        faultEn = 1'b1;
        runCmd(2'b01, 8'd5, d, rv);
        faultEn = 1'b0;
        expValue = nextValue(expValue, 2'b01, 5, 2);
        checks++; if (d !== 28) begin fails++; $display("[TB] FAIL err_done: got %0d expected 28", d); end
        checks++; if (countRises() !== 2) begin fails++; $display("[TB] FAIL err_pulses: got %0d expected 2", countRises()); end
        checks++; if (dutError !== 1'b1) begin fails++; $display("[TB] FAIL err_flag: got %b expected 1", dutError); end
        checks++; if (int'(dutValue) !== expValue) begin fails++; $display("[TB] FAIL err_value: got %0d expected %0d", dutValue, expValue); end
        runCmd(2'b00, 8'd0, d, rv);
        checks++; if (d !== 1) begin fails++; $display("[TB] FAIL nop_done: got %0d expected 1", d); end
        checks++; if (dutError !== 1'b0) begin fails++; $display("[TB] FAIL nop_clears_error: got %b expected 0", dutError); end
    endtask

    task automatic test_reset_abort();
        int d, rv, doneSeen, stepSeen;
        @(negedge clk);
        cmdValid = 1'b1; cmdOp = 2'b01; cmdArg = 8'd4;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0; cmdOp = 2'b00; cmdArg = 8'd0;
        repeat (2) @(negedge clk);
        checks++; if (dutStep !== 1'b1) begin fails++; $display("[TB] FAIL abort_in_pulse: got %b expected 1", dutStep); end
        rstN = 1'b0;
        @(negedge clk);
        checks++; if (dutStep !== 1'b0) begin fails++; $display("[TB] FAIL abort_step: got %b expected 0", dutStep); end
        checks++; if (dutValue !== 8'd0) begin fails++; $display("[TB] FAIL abort_value: got %0d expected 0", dutValue); end
        doneSeen = int'(dutDone);
        @(negedge clk);
        rstN = 1'b1;
        expValue = 0;
        stepSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            doneSeen += int'(dutDone);
            stepSeen += int'(dutStep);
        end
        checks++; if (doneSeen !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", doneSeen); end
        checks++; if (stepSeen !== 0) begin fails++; $display("[TB] FAIL abort_no_step: got %0d step cycles expected 0", stepSeen); end
        runCmd(2'b01, 8'd0, d, rv);
        checks++; if (d !== 1) begin fails++; $display("[TB] FAIL inc0_done: got %0d expected 1", d); end
        checks++; if (countRises() !== 0) begin fails++; $display("[TB] FAIL inc0_pulses: got %0d expected 0", countRises()); end
        checks++; if (int'(dutValue) !== 0) begin fails++; $display("[TB] FAIL inc0_value: got %0d expected 0", dutValue); end
    endtask

    task automatic test_random();
        int d, rv, n;
        logic [1:0] op;
        logic [7:0] arg;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            arg = (op == 2'b11) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            runCmd(op, arg, d, rv);
            n = expPulses(op, int'(arg));
            expValue = nextValue(expValue, op, int'(arg), n);
            checks++; if (d !== expDone(op, int'(arg))) begin fails++; $display("[TB] FAIL rnd%0d_done op=%0d arg=%0d: got %0d expected %0d", i, op, arg, d, expDone(op, int'(arg))); end
            checks++; if (countRises() !== n) begin fails++; $display("[TB] FAIL rnd%0d_pulses: got %0d expected %0d", i, countRises(), n); end
            checks++; if (int'(dutValue) !== expValue) begin fails++; $display("[TB] FAIL rnd%0d_value: got %0d expected %0d", i, dutValue, expValue); end
            checks++; if (dutError !== 1'b0) begin fails++; $display("[TB] FAIL rnd%0d_error: got %b expected 0", i, dutError); end
        end
    endtask

    initial begin
        $display("[TB] data_counter_sequencer bench start");
        test_reset();
        test_inc();
        test_load_wrap();
        test_dec();
        test_error();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
